// File: rtl/circulant_shift_pipe.sv
// -----------------------------------------------------------------------------
// circulant_shift_pipe
//
// Two-stage, valid/ready handshaked cyclic shifter for QC-LDPC circulants.
// The Z-bit field sits in the top Z bits of an MAX_BLOCK_SIZE-wide vector and
// is rotated left or right by a per-beat amount. Stage 1 captures the beat,
// masks the field, classifies it (null / error / normal) and resolves the
// request into an equivalent left rotation. Stage 2 performs the rotation and
// holds the result on the out_* ports until downstream accepts it.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   in_valid      input beat valid
//   in_ready      block accepts a beat this cycle
//   in_vector     input data, field in [MAX-1 : MAX-Z]
//   shift_amount  rotate amount; all-ones selects the null circulant
//   block_size    lifting size Z, legal 1..MAX_BLOCK_SIZE
//   dir_right     0 = rotate toward MSB, 1 = rotate toward LSB
//   in_tag        sideband returned unchanged with the result
//   out_valid     result beat valid
//   out_ready     downstream accepts the result
//   out_vector    rotated field, bits below the field are 0
//   out_tag       tag of the beat on out_vector
//   out_null      beat was a null circulant
//   out_err       beat had an illegal Z or shift
// -----------------------------------------------------------------------------
module circulant_shift_pipe #(
    parameter  int MAX_BLOCK_SIZE = 64,
    parameter  int TAG_W          = 8,
    localparam int WIDTH          = $clog2(MAX_BLOCK_SIZE)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [MAX_BLOCK_SIZE-1:0] in_vector,
    input  logic [WIDTH-1:0]          shift_amount,
    input  logic [WIDTH:0]            block_size,
    input  logic                      dir_right,
    input  logic [TAG_W-1:0]          in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MAX_BLOCK_SIZE-1:0] out_vector,
    output logic [TAG_W-1:0]          out_tag,
    output logic                      out_null,
    output logic                      out_err
);

    localparam int MAX = MAX_BLOCK_SIZE;

    typedef logic [WIDTH:0] z_t;

    localparam z_t               MAX_Z      = z_t'(MAX_BLOCK_SIZE);
    localparam logic [WIDTH-1:0] NULL_SHIFT = '1;

    // Stage 1 state
    logic             s1_full_q,  s1_full_d;
    logic [MAX-1:0]   s1_field_q, s1_field_d;
    z_t               s1_shift_q, s1_shift_d;   // equivalent left rotation
    z_t               s1_z_q,     s1_z_d;
    logic             s1_null_q,  s1_null_d;
    logic             s1_err_q,   s1_err_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

    // Stage 2 state (drives the out_* ports)
    logic             out_valid_q,  out_valid_d;
    logic [MAX-1:0]   out_vector_q, out_vector_d;
    logic [TAG_W-1:0] out_tag_q,    out_tag_d;
    logic             out_null_q,   out_null_d;
    logic             out_err_q,    out_err_d;

    logic             s2_advance;
    logic             in_null;
    logic             in_err;
    logic [MAX-1:0]   in_mask;
    z_t               right_amt;
    z_t               s2_lo;
    logic [MAX-1:0]   s2_f;
    logic [MAX-1:0]   s2_rot;
    logic [MAX-1:0]   rot_vector;

    assign s2_advance = !out_valid_q || out_ready;
    assign in_ready   = !rst && (!s1_full_q || s2_advance);

    // Classification of the incoming beat. The null code is checked first so
    // that it wins over any range violation of Z or the shift.
    always_comb begin : s1_decode
        in_null   = (shift_amount == NULL_SHIFT);
        in_err    = !in_null && ((block_size == '0) || (block_size > MAX_Z) ||
                                 ({1'b0, shift_amount} >= block_size));
        // Top Z bits set; only consumed for legal Z.
        in_mask   = ~({MAX{1'b1}} >> block_size);
        // Right rotation by s equals left rotation by Z-s (s=0 handled below).
        right_amt = block_size - {1'b0, shift_amount};
    end

    // NOTE: every combinational output is given its hold/default value first,
    // so no path through the if-tree leaves a signal unassigned (no latches).
    always_comb begin : s1_next
        s1_full_d  = s1_full_q;
        s1_field_d = s1_field_q;
        s1_shift_d = s1_shift_q;
        s1_z_d     = s1_z_q;
        s1_null_d  = s1_null_q;
        s1_err_d   = s1_err_q;
        s1_tag_d   = s1_tag_q;
        if (in_ready) begin
            s1_full_d = in_valid;
            if (in_valid) begin
                s1_tag_d  = in_tag;
                s1_null_d = in_null;
                s1_err_d  = in_err;
                if (in_null || in_err) begin
                    // Zero data with a legal Z keeps the stage-2 shifters in
                    // range and yields an all-zero result for free.
                    s1_field_d = '0;
                    s1_shift_d = '0;
                    s1_z_d     = MAX_Z;
                end else begin
                    s1_field_d = in_vector & in_mask;
                    s1_z_d     = block_size;
                    s1_shift_d = (dir_right && (shift_amount != '0)) ? right_amt
                                                                     : {1'b0, shift_amount};
                end
            end
        end
    end

    // Rotation: bring the field down to bit 0, rotate within Z bits, put it
    // back on top. Bits pushed past MAX by the left shift are >= Z and would be
    // masked anyway, so MAX-wide arithmetic is sufficient.
    always_comb begin : s2_rotate
        s2_lo      = MAX_Z - s1_z_q;
        s2_f       = s1_field_q >> s2_lo;
        s2_rot     = ((s2_f << s1_shift_q) | (s2_f >> (s1_z_q - s1_shift_q)))
                     & ({MAX{1'b1}} >> s2_lo);
        rot_vector = s2_rot << s2_lo;
    end

    always_comb begin : s2_next
        out_valid_d  = out_valid_q;
        out_vector_d = out_vector_q;
        out_tag_d    = out_tag_q;
        out_null_d   = out_null_q;
        out_err_d    = out_err_q;
        if (s2_advance) begin
            out_valid_d = s1_full_q;
            if (s1_full_q) begin
                out_vector_d = rot_vector;
                out_tag_d    = s1_tag_q;
                out_null_d   = s1_null_q;
                out_err_d    = s1_err_q;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every flop
    // samples the pre-edge value of its _d regardless of process order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the S1 payload is qualified by s1_full_q and would not need
            // clearing; it is reset anyway so the post-reset state is fully known.
            s1_full_q    <= 1'b0;
            s1_field_q   <= '0;
            s1_shift_q   <= '0;
            s1_z_q       <= MAX_Z;
            s1_null_q    <= 1'b0;
            s1_err_q     <= 1'b0;
            s1_tag_q     <= '0;
            out_valid_q  <= 1'b0;
            out_vector_q <= '0;
            out_tag_q    <= '0;
            out_null_q   <= 1'b0;
            out_err_q    <= 1'b0;
        end else begin
            s1_full_q    <= s1_full_d;
            s1_field_q   <= s1_field_d;
            s1_shift_q   <= s1_shift_d;
            s1_z_q       <= s1_z_d;
            s1_null_q    <= s1_null_d;
            s1_err_q     <= s1_err_d;
            s1_tag_q     <= s1_tag_d;
            out_valid_q  <= out_valid_d;
            out_vector_q <= out_vector_d;
            out_tag_q    <= out_tag_d;
            out_null_q   <= out_null_d;
            out_err_q    <= out_err_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_vector = out_vector_q;
    assign out_tag    = out_tag_q;
    assign out_null   = out_null_q;
    assign out_err    = out_err_q;

endmodule

// File: tb/tb_circulant_shift_pipe.sv
// -----------------------------------------------------------------------------
// tb_circulant_shift_pipe
//
// Directed bench for circulant_shift_pipe at MAX_BLOCK_SIZE=8 (field of Z=5 is
// bits [7:3]). A scoreboard built from a bit-by-bit rotation model checks every
// emitted beat, the in_ready rule and payload stability under stall; directed
// beats additionally pin literal results and latency.
// -----------------------------------------------------------------------------
module tb_circulant_shift_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_vector;
    logic [2:0] shift_amount;
    logic [3:0] block_size;
    logic       dir_right;
    logic [7:0] in_tag;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_vector;
    logic [7:0] out_tag;
    logic       out_null;
    logic       out_err;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] vec;
        logic [7:0] tag;
        logic       nul;
        logic       err;
    } beat_t;

    beat_t exp_q[$];

    circulant_shift_pipe #(
        .MAX_BLOCK_SIZE(8),
        .TAG_W         (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_vector   (in_vector),
        .shift_amount(shift_amount),
        .block_size  (block_size),
        .dir_right   (dir_right),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_vector  (out_vector),
        .out_tag     (out_tag),
        .out_null    (out_null),
        .out_err     (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: move each field bit individually to its rotated position.
    function automatic beat_t model(input logic [7:0] v, input int s, input int z,
                                    input logic dir, input logic [7:0] tag);
        beat_t b;
        b.tag = tag;
        b.vec = 8'h00;
        b.nul = (s == 7);
        b.err = !b.nul && (z == 0 || z > 8 || s >= z);
        if (!b.nul && !b.err) begin
            for (int j = 0; j < z; j++) begin
                int dst;
                dst = dir ? (j - s + z) % z : (j + s) % z;
                b.vec[8 - z + dst] = v[8 - z + j];
            end
        end
        return b;
    endfunction

    // Scoreboard / protocol monitor, sampled mid-cycle.
    initial begin
        beat_t held;
        beat_t cur;
        beat_t e;
        bit    prev_stall;
        prev_stall = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            cur = '{vec: out_vector, tag: out_tag, nul: out_null, err: out_err};
            if (rst) begin
                check("ready_in_reset", 32'(in_ready), 32'd0);
                exp_q.delete();
                prev_stall = 1'b0;
            end else begin
                check("in_ready_rule", 32'(in_ready),
                      32'(!(exp_q.size() == 2 && !out_ready)));
                if (prev_stall)
                    check("stall_hold", 32'({out_valid, cur}), 32'({1'b1, held}));
                if (out_valid && out_ready) begin
                    check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("beat_payload", 32'(cur), 32'(e));
                    end
                end
                if (in_valid && in_ready)
                    exp_q.push_back(model(in_vector, int'(shift_amount), int'(block_size),
                                          dir_right, in_tag));
                prev_stall = out_valid && !out_ready;
                held       = cur;
            end
        end
    end

    // One isolated beat with a hand-computed expected result.
    task automatic run_beat(input string name, input logic [7:0] v, input logic [2:0] s,
                            input logic [3:0] z, input logic dir, input logic [7:0] tag,
                            input logic [7:0] ev, input logic en, input logic ee);
        int lat;
        bit acc;
        out_ready    = 1'b1;
        in_vector    = v;
        shift_amount = s;
        block_size   = z;
        dir_right    = dir;
        in_tag       = tag;
        in_valid     = 1'b1;
        acc          = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check({name, "_accept"}, 32'(acc), 32'd1);
        // lat counts edges from the accept edge up to the one that shows the result
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
            @(negedge clk);
        end
        check({name, "_latency"}, 32'(lat), 32'd2);
        check({name, "_result"}, 32'({out_vector, out_tag, out_null, out_err}),
              32'({ev, tag, en, ee}));
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sv [8] = '{8'hB0, 8'hB7, 8'h81, 8'h81, 8'h5A, 8'hFF, 8'h3C, 8'hE1};
    logic [2:0] ss [8] = '{3'd2, 3'd2, 3'd1, 3'd1, 3'd7, 3'd3, 3'd4, 3'd6};
    logic [3:0] sz [8] = '{4'd5, 4'd5, 4'd8, 4'd8, 4'd6, 4'd3, 4'd4, 4'd7};
    logic       sd [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int         pat [4] = '{1, 0, 0, 1};

    initial begin
        int idx;
        rst          = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        in_vector    = 8'h00;
        shift_amount = 3'd0;
        block_size   = 4'd5;
        dir_right    = 1'b0;
        in_tag       = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_state",
              32'({out_valid, in_ready, out_vector, out_tag, out_null, out_err}),
              32'({1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0}));
        @(posedge clk);
        #1;

        // Directed beats, Z=5 field = bits [7:3] unless noted
        run_beat("left2",      8'hB0, 3'd2, 4'd5, 1'b0, 8'hA0, 8'hD0, 1'b0, 1'b0);
        run_beat("left2_junk", 8'hB7, 3'd2, 4'd5, 1'b0, 8'hA1, 8'hD0, 1'b0, 1'b0);
        run_beat("right2",     8'hB0, 3'd2, 4'd5, 1'b1, 8'hA2, 8'hA8, 1'b0, 1'b0);
        run_beat("s0_left",    8'hB0, 3'd0, 4'd5, 1'b0, 8'hA3, 8'hB0, 1'b0, 1'b0);
        run_beat("s0_right",   8'hB7, 3'd0, 4'd5, 1'b1, 8'hA4, 8'hB0, 1'b0, 1'b0);
        run_beat("null",       8'hB0, 3'd7, 4'd5, 1'b0, 8'hA5, 8'h00, 1'b1, 1'b0);
        run_beat("null_z0",    8'hB0, 3'd7, 4'd0, 1'b1, 8'hA6, 8'h00, 1'b1, 1'b0);
        run_beat("s_eq_z",     8'hB0, 3'd5, 4'd5, 1'b0, 8'hA7, 8'h00, 1'b0, 1'b1);
        run_beat("z0",         8'hB0, 3'd1, 4'd0, 1'b0, 8'hA8, 8'h00, 1'b0, 1'b1);
        run_beat("z9",         8'hB0, 3'd1, 4'd9, 1'b0, 8'hA9, 8'h00, 1'b0, 1'b1);
        run_beat("z8_left",    8'h81, 3'd1, 4'd8, 1'b0, 8'hAA, 8'h03, 1'b0, 1'b0);
        run_beat("z8_right",   8'h81, 3'd1, 4'd8, 1'b1, 8'hAB, 8'hC0, 1'b0, 1'b0);
        run_beat("z1_pass",    8'hFF, 3'd0, 4'd1, 1'b1, 8'hAC, 8'h80, 1'b0, 1'b0);
        run_beat("err_clear",  8'hB0, 3'd1, 4'd5, 1'b0, 8'hAD, 8'h68, 1'b0, 1'b0);

        // Back-to-back stream with out_ready toggling 1,0,0,1
        idx = 0;
        for (int c = 0; c < 200; c++) begin
            if (idx == 8 && exp_q.size() == 0) break;
            out_ready = (pat[c % 4] != 0);
            in_valid  = (idx < 8);
            if (idx < 8) begin
                in_vector    = sv[idx];
                shift_amount = ss[idx];
                block_size   = sz[idx];
                dir_right    = sd[idx];
                in_tag       = 8'(idx);
            end
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_sent", 32'(idx), 32'd8);
        check("stream_drained", 32'(exp_q.size()), 32'd0);

        // Reset with two beats in flight
        out_ready    = 1'b0;
        in_vector    = 8'hB0;
        shift_amount = 3'd2;
        block_size   = 4'd5;
        dir_right    = 1'b0;
        in_tag       = 8'h55;
        in_valid     = 1'b1;
        @(posedge clk);
        #1 in_tag = 8'h66;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_stale", 32'({out_valid, out_vector, out_tag}), 32'd0);
            @(posedge clk);
            #1;
        end

        // Pipeline still works after the mid-stream reset
        run_beat("post_rst", 8'hB0, 3'd2, 4'd5, 1'b0, 8'h77, 8'hD0, 1'b0, 1'b0);
        check("final_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
